// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded ID fields, RF operands, writeback bypass,
// flush/hold controls in; registered EX fields, stall and stall count out.
// Ports (slave = stage register, master = ID side / environment):
//   id_*     decoded instruction and RegisterFile DATA1/DATA2
//   wb_*     same-cycle writeback used for operand bypass
//   flush    squash ID instruction; hold freezes the EX slot
//   ex_*     registered EX slot; stall_o, stall_count status
interface id_ex_stage_reg_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [4:0]        id_rd;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic [XLEN-1:0]   id_rf_data1;
    logic [XLEN-1:0]   id_rf_data2;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              hold;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_imm;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_imm, id_ctrl, id_mem_read, id_rf_data1, id_rf_data2,
        output wb_we, wb_rd, wb_data, flush, hold,
        input  ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
        input  ex_op1, ex_op2, ex_ctrl, ex_mem_read, stall_o, stall_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_imm, id_ctrl, id_mem_read, id_rf_data1, id_rf_data2,
        input  wb_we, wb_rd, wb_data, flush, hold,
        output ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd,
        output ex_op1, ex_op2, ex_ctrl, ex_mem_read, stall_o, stall_count
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with WB->operand bypass, load-use detection,
// bubble insertion and a saturating stall-cycle counter.
// Ports: CLK (rising edge), RESET (sync, active-high),
//   bus : id_ex_stage_reg_if.slave (ID/WB inputs, EX outputs, stall)
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input logic              CLK,
    input logic              RESET,
    id_ex_stage_reg_if.slave bus
);
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             luh;
    logic             stall;
    logic [XLEN-1:0]  op1_d, op2_d;

    // Load in EX whose result the ID instruction needs; x0 never hazards.
    assign luh = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) &
                 bus.id_valid &
                 ((bus.id_uses_rs1 & (bus.id_rs1 == ex_q.rd)) |
                  (bus.id_uses_rs2 & (bus.id_rs2 == ex_q.rd)));

    // Flush squashes the ID instruction, so nothing upstream must hold.
    assign stall = ~RESET & ~bus.flush & (bus.hold | luh);

    // Same-cycle writeback overrides the stale RF read.
    assign op1_d = (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs1)
                 ? bus.wb_data : bus.id_rf_data1;
    assign op2_d = (bus.wb_we && bus.wb_rd != 5'd0 && bus.wb_rd == bus.id_rs2)
                 ? bus.wb_data : bus.id_rf_data2;

    always_comb begin
        ex_d = '0;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (luh || !bus.id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid    = 1'b1;
            ex_d.pc       = bus.id_pc;
            ex_d.imm      = bus.id_imm;
            ex_d.rs1      = bus.id_rs1;
            ex_d.rs2      = bus.id_rs2;
            ex_d.rd       = bus.id_rd;
            ex_d.op1      = op1_d;
            ex_d.op2      = op2_d;
            ex_d.ctrl     = bus.id_ctrl;
            ex_d.mem_read = bus.id_mem_read;
        end
    end

    // Saturate instead of wrapping so a long run never reads as short.
    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_imm      = ex_q.imm;
    assign bus.ex_rs1      = ex_q.rs1;
    assign bus.ex_rs2      = ex_q.rs2;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_op1      = ex_q.op1;
    assign bus.ex_op2      = ex_q.op2;
    assign bus.ex_ctrl     = ex_q.ctrl;
    assign bus.ex_mem_read = ex_q.mem_read;
    assign bus.stall_o     = stall;
    assign bus.stall_count = cnt_q;
endmodule
